// File: rtl/scpu8_mem_system.sv
// scpu8_mem_system: multi-cycle 16-bit CPU sharing one byte-wide RAM for
// code and data; every word moves as two little-endian byte accesses.
module scpu8_mem_system #(
    parameter int         MEM_ADDR_WIDTH = 10,
    parameter logic [8:0] BOOT_ADDR      = 9'd0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      ld_we,
    input  logic [MEM_ADDR_WIDTH-1:0] ld_addr,
    input  logic [7:0]                ld_data,
    output logic [7:0]                ld_rdata,
    output logic                      running,
    output logic                      halted,
    output logic [MEM_ADDR_WIDTH-2:0] pc
);
    localparam int PW = MEM_ADDR_WIDTH - 1;

    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_SET   = 5'b01100;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_L,
        S_FETCH_H,
        S_EXEC,
        S_MEM_L,
        S_MEM_H
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       pc_q, pc_d;
    logic [PW-1:0]       ea_q, ea_d;
    logic [15:0]         ir_q, ir_d;
    logic [7:0]          mdr_q, mdr_d;
    logic [15:0]         gr_q [8];
    logic [15:0]         gr_d [8];
    logic                zf_q, zf_d;
    logic                nf_q, nf_d;
    logic                cf_q, cf_d;
    logic                halted_q, halted_d;

    logic [7:0]          mem_q [2**MEM_ADDR_WIDTH];
    logic                mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [MEM_ADDR_WIDTH-1:0] cpu_addr;
    logic [7:0]          mem_wdata;
    logic [7:0]          cpu_rdata;

    logic [4:0]          op;
    logic [2:0]          r1, r2, r3;
    logic [7:0]          imm8;
    logic [3:0]          off4;

    logic                alu_en, alu_sub;
    logic [15:0]         alu_a, alu_b;
    logic [16:0]         alu_res;

    assign op   = ir_q[15:11];
    assign r1   = ir_q[10:8];
    assign r2   = ir_q[6:4];
    assign r3   = ir_q[2:0];
    assign imm8 = ir_q[7:0];
    assign off4 = ir_q[3:0];

    assign running  = (state_q != S_IDLE);
    assign halted   = halted_q;
    assign pc       = pc_q;
    assign ld_rdata = mem_q[ld_addr];
    assign cpu_rdata = mem_q[cpu_addr];

    always_comb begin
        unique case (state_q)
            S_FETCH_H: cpu_addr = {pc_q, 1'b1};
            S_MEM_L:   cpu_addr = {ea_q, 1'b0};
            S_MEM_H:   cpu_addr = {ea_q, 1'b1};
            default:   cpu_addr = {pc_q, 1'b0};
        endcase
    end

    // Bit 16 is carry-out for add and borrow for subtract.
    always_comb begin
        alu_en  = 1'b0;
        alu_sub = 1'b0;
        alu_a   = gr_q[r2];
        alu_b   = gr_q[r3];
        unique case (op)
            OP_ADD: alu_en = 1'b1;
            OP_SUB: begin
                alu_en  = 1'b1;
                alu_sub = 1'b1;
            end
            OP_ADDI: begin
                alu_en = 1'b1;
                alu_a  = gr_q[r1];
                alu_b  = {8'h00, imm8};
            end
            OP_SUBI: begin
                alu_en  = 1'b1;
                alu_sub = 1'b1;
                alu_a   = gr_q[r1];
                alu_b   = {8'h00, imm8};
            end
            default: ;
        endcase
        if (alu_sub) alu_res = {1'b0, alu_a} - {1'b0, alu_b};
        else         alu_res = {1'b0, alu_a} + {1'b0, alu_b};
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ea_d      = ea_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        gr_d      = gr_q;
        zf_d      = zf_q;
        nf_d      = nf_q;
        cf_d      = cf_q;
        halted_d  = halted_q;
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;

        if (state_q == S_IDLE && ld_we) mem_we = 1'b1;

        if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_d     = PW'(BOOT_ADDR);
                        halted_d = 1'b0;
                        state_d  = S_FETCH_L;
                    end
                end
                S_FETCH_L: begin
                    ir_d[7:0] = cpu_rdata;
                    state_d   = S_FETCH_H;
                end
                S_FETCH_H: begin
                    ir_d[15:8] = cpu_rdata;
                    pc_d       = pc_q + PW'(1);
                    state_d    = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH_L;
                    if (alu_en) begin
                        gr_d[r1] = alu_res[15:0];
                        zf_d     = (alu_res[15:0] == 16'h0000);
                        nf_d     = alu_res[15];
                        cf_d     = alu_res[16];
                    end
                    unique case (op)
                        OP_HALT: begin
                            halted_d = 1'b1;
                            state_d  = S_IDLE;
                        end
                        OP_LOAD, OP_STORE: begin
                            ea_d    = PW'(gr_q[r2] + {12'h000, off4});
                            state_d = S_MEM_L;
                        end
                        OP_SET:  gr_d[r1] = {8'h00, imm8};
                        OP_JUMP: pc_d = PW'(imm8);
                        OP_BZ:   if (zf_q) pc_d = PW'(imm8);
                        OP_BNZ:  if (!zf_q) pc_d = PW'(imm8);
                        default: ;
                    endcase
                end
                S_MEM_L: begin
                    state_d = S_MEM_H;
                    if (op == OP_LOAD) begin
                        mdr_d = cpu_rdata;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = cpu_addr;
                        mem_wdata = gr_q[r1][7:0];
                    end
                end
                S_MEM_H: begin
                    state_d = S_FETCH_L;
                    if (op == OP_LOAD) begin
                        gr_d[r1] = {cpu_rdata, mdr_q};
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = cpu_addr;
                        mem_wdata = gr_q[r1][15:8];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        gr_d[0] = 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ea_q     <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            gr_q     <= '{default: '0};
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ea_q     <= ea_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            gr_q     <= gr_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            cf_q     <= cf_d;
            halted_q <= halted_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_scpu8_mem_system.sv
// tb_scpu8_mem_system: directed and random programs checked against an
// instruction-level model of the CPU kept in the bench.
module tb_scpu8_mem_system;
    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] HALT  = 5'b00001;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] STORE = 5'b00011;
    localparam logic [4:0] ADD   = 5'b01000;
    localparam logic [4:0] ADDI  = 5'b01001;
    localparam logic [4:0] SUB   = 5'b01010;
    localparam logic [4:0] SUBI  = 5'b01011;
    localparam logic [4:0] SET   = 5'b01100;
    localparam logic [4:0] JUMP  = 5'b11000;
    localparam logic [4:0] BZ    = 5'b11010;
    localparam logic [4:0] BNZ   = 5'b11011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       ld_we = 1'b0;
    logic [9:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [7:0] ld_rdata;
    logic       running;
    logic       halted;
    logic [8:0] pc;

    int n_cmp = 0;
    int n_bad = 0;
    int base_cyc = 0;

    logic [7:0]  m_mem [1024];
    logic [15:0] m_gr [8];
    logic        m_zf, m_nf, m_cf;
    int          m_pc, m_cyc;

    scpu8_mem_system #(
        .MEM_ADDR_WIDTH(10),
        .BOOT_ADDR(9'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .start(start),
        .ld_we(ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_rdata(ld_rdata),
        .running(running),
        .halted(halted),
        .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc_ri(logic [4:0] op, int a, int imm);
        return {op, 3'(a), 8'(imm)};
    endfunction

    function automatic logic [15:0] enc_rrr(logic [4:0] op, int a, int b, int c);
        return {op, 3'(a), 1'b0, 3'(b), 1'b0, 3'(c)};
    endfunction

    function automatic logic [15:0] enc_mem(logic [4:0] op, int a, int b, int off);
        return {op, 3'(a), 1'b0, 3'(b), 4'(off)};
    endfunction

    task automatic ld_byte(input int a, input logic [7:0] d);
        @(negedge clk);
        ld_we = 1'b1;
        ld_addr = 10'(a);
        ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic ld_word(input int w, input logic [15:0] v);
        ld_byte(2 * w, v[7:0]);
        ld_byte(2 * w + 1, v[15:8]);
    endtask

    task automatic rd_byte(input int a, output logic [7:0] d);
        @(negedge clk);
        ld_addr = 10'(a);
        #1 d = ld_rdata;
    endtask

    // Executes from BOOT_ADDR until HALT; 3 cycles per instruction, 5 for memory ops.
    task automatic model_run();
        logic [15:0] ir, res;
        logic [4:0]  op;
        int r1, r2, r3, ea, va, vb;
        bit arith;
        m_pc = 0;
        m_cyc = 0;
        for (int step = 0; step < 1000; step++) begin
            ir = {m_mem[2 * m_pc + 1], m_mem[2 * m_pc]};
            m_pc = (m_pc + 1) % 512;
            m_cyc += 3;
            op = ir[15:11];
            r1 = int'(ir[10:8]);
            r2 = int'(ir[6:4]);
            r3 = int'(ir[2:0]);
            ea = (int'(m_gr[r2]) + int'(ir[3:0])) % 512;
            arith = 1'b0;
            va = 0;
            vb = 0;
            case (op)
                HALT: return;
                LOAD: begin
                    if (r1 != 0) m_gr[r1] = {m_mem[2 * ea + 1], m_mem[2 * ea]};
                    m_cyc += 2;
                end
                STORE: begin
                    m_mem[2 * ea] = m_gr[r1][7:0];
                    m_mem[2 * ea + 1] = m_gr[r1][15:8];
                    m_cyc += 2;
                end
                ADD, SUB: begin
                    arith = 1'b1;
                    va = int'(m_gr[r2]);
                    vb = int'(m_gr[r3]);
                end
                ADDI, SUBI: begin
                    arith = 1'b1;
                    va = int'(m_gr[r1]);
                    vb = int'(ir[7:0]);
                end
                SET: if (r1 != 0) m_gr[r1] = {8'h00, ir[7:0]};
                JUMP: m_pc = int'(ir[7:0]);
                BZ: if (m_zf) m_pc = int'(ir[7:0]);
                BNZ: if (!m_zf) m_pc = int'(ir[7:0]);
                default: ;
            endcase
            if (arith) begin
                if (op == ADD || op == ADDI) begin
                    m_cf = (va + vb) > 65535;
                    res = 16'((va + vb) % 65536);
                end else begin
                    m_cf = va < vb;
                    res = 16'((va - vb + 65536) % 65536);
                end
                m_zf = (res == 16'h0000);
                m_nf = res[15];
                if (r1 != 0) m_gr[r1] = res;
            end
        end
    endtask

    task automatic dut_run(input int budget, input int frz_at, input int frz_len,
                           input bit try_ld, output int cyc, output bit ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        ok = 1'b0;
        while (cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
            if (cyc == frz_at) enable = 1'b0;
            if (cyc == frz_at + frz_len) enable = 1'b1;
            if (try_ld && cyc == 5) begin
                ld_we = 1'b1;
                ld_addr = 10'd2;
                ld_data = 8'h55;
            end else if (try_ld && cyc == 6) begin
                ld_we = 1'b0;
            end
        end
        ld_we = 1'b0;
        enable = 1'b1;
    endtask

    task automatic load_sum_prog();
        ld_word(0, enc_ri(JUMP, 0, 8'h10));
        ld_word(16, enc_ri(SET, 3, 4));
        ld_word(17, enc_ri(SET, 1, 0));
        ld_word(18, enc_rrr(ADD, 1, 1, 3));
        ld_word(19, enc_ri(SUBI, 3, 1));
        ld_word(20, enc_ri(BNZ, 0, 8'h12));
        ld_word(21, enc_mem(STORE, 1, 0, 2));
        ld_word(22, enc_ri(HALT, 0, 0));
        ld_word(2, 16'h0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        #12;
        n_cmp++;
        if (running !== 1'b0) begin n_bad++; $display("FAIL rst_running: got %0b want 0", running); end
        n_cmp++;
        if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %0b want 0", halted); end
        n_cmp++;
        if (pc !== 9'd0) begin n_bad++; $display("FAIL rst_pc: got %0d want 0", pc); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (dut.gr_q[i] !== 16'h0) begin n_bad++; $display("FAIL rst_gr%0d: got %h want 0000", i, dut.gr_q[i]); end
        end
        n_cmp++;
        if ({dut.zf_q, dut.nf_q, dut.cf_q} !== 3'b000) begin
            n_bad++; $display("FAIL rst_flags: got %b want 000", {dut.zf_q, dut.nf_q, dut.cf_q});
        end
        for (int i = 0; i < 8; i++) m_gr[i] = 16'h0;
        m_zf = 1'b0; m_nf = 1'b0; m_cf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loadport();
        logic [7:0] d;
        for (int a = 0; a < 1024; a++) ld_byte(a, 8'h00);
        ld_byte(2, 8'hAB);
        ld_byte(5, 8'h3C);
        rd_byte(2, d);
        n_cmp++;
        if (d !== 8'hAB) begin n_bad++; $display("FAIL ld_byte2: got %h want ab", d); end
        rd_byte(5, d);
        n_cmp++;
        if (d !== 8'h3C) begin n_bad++; $display("FAIL ld_byte5: got %h want 3c", d); end
        rd_byte(4, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL ld_byte4: got %h want 00", d); end
    endtask

    task automatic test_loop_sum();
        int cyc;
        bit ok;
        logic [7:0] d;
        load_sum_prog();
        model_run();
        dut_run(320, -1, 0, 1'b1, cyc, ok);
        base_cyc = cyc;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL sum_halt: halted=%0b want 1 within 320", halted); end
        n_cmp++;
        if (cyc != m_cyc) begin n_bad++; $display("FAIL sum_cycles: got %0d want %0d", cyc, m_cyc); end
        n_cmp++;
        if (pc !== 9'd23) begin n_bad++; $display("FAIL sum_pc: got %0d want 23", pc); end
        n_cmp++;
        if (running !== 1'b0) begin n_bad++; $display("FAIL sum_running: got %0b want 0", running); end
        rd_byte(4, d);
        n_cmp++;
        if (d !== 8'h0A) begin n_bad++; $display("FAIL sum_lo: got %h want 0a", d); end
        rd_byte(5, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL sum_hi: got %h want 00", d); end
        rd_byte(2, d);
        n_cmp++;
        if (d !== m_mem[2]) begin n_bad++; $display("FAIL ld_while_run: got %h want %h", d, m_mem[2]); end
    endtask

    task automatic test_load_flags();
        int cyc;
        bit ok;
        logic [7:0] d;
        ld_word(0, enc_ri(JUMP, 0, 8'h20));
        ld_word(1, 16'h00AB);
        ld_word(3, 16'hA55A);
        ld_word(32, enc_mem(LOAD, 2, 0, 1));
        ld_word(33, enc_ri(SUBI, 2, 8'hAB));
        ld_word(34, enc_mem(STORE, 2, 0, 3));
        ld_word(35, enc_ri(HALT, 0, 0));
        model_run();
        dut_run(320, -1, 0, 1'b0, cyc, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL lf_halt: halted=%0b want 1", halted); end
        n_cmp++;
        if (cyc != m_cyc) begin n_bad++; $display("FAIL lf_cycles: got %0d want %0d", cyc, m_cyc); end
        n_cmp++;
        if (dut.zf_q !== 1'b1) begin n_bad++; $display("FAIL lf_zf: got %0b want 1", dut.zf_q); end
        n_cmp++;
        if (dut.cf_q !== 1'b0) begin n_bad++; $display("FAIL lf_cf: got %0b want 0", dut.cf_q); end
        n_cmp++;
        if (dut.gr_q[2] !== m_gr[2]) begin n_bad++; $display("FAIL lf_gr2: got %h want %h", dut.gr_q[2], m_gr[2]); end
        rd_byte(6, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL lf_b6: got %h want 00", d); end
        rd_byte(7, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL lf_b7: got %h want 00", d); end
    endtask

    task automatic test_carry();
        int cyc;
        bit ok;
        ld_word(0, enc_ri(JUMP, 0, 8'h30));
        ld_word(48, enc_ri(SET, 1, 0));
        ld_word(49, enc_ri(SUBI, 1, 1));
        ld_word(50, enc_ri(BZ, 0, 8'h36));
        ld_word(51, enc_ri(SET, 4, 8'h77));
        ld_word(52, enc_ri(HALT, 0, 0));
        ld_word(53, enc_ri(NOP, 0, 0));
        ld_word(54, enc_ri(SET, 5, 8'h99));
        ld_word(55, enc_ri(HALT, 0, 0));
        model_run();
        dut_run(320, -1, 0, 1'b0, cyc, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL cy_halt: halted=%0b want 1", halted); end
        n_cmp++;
        if (dut.gr_q[1] !== 16'hFFFF) begin n_bad++; $display("FAIL cy_gr1: got %h want ffff", dut.gr_q[1]); end
        n_cmp++;
        if ({dut.zf_q, dut.nf_q, dut.cf_q} !== 3'b011) begin
            n_bad++; $display("FAIL cy_flags: zf/nf/cf got %b want 011", {dut.zf_q, dut.nf_q, dut.cf_q});
        end
        n_cmp++;
        if (dut.gr_q[4] !== 16'h0077) begin n_bad++; $display("FAIL cy_gr4: got %h want 0077", dut.gr_q[4]); end
        n_cmp++;
        if (dut.gr_q[5] !== m_gr[5]) begin n_bad++; $display("FAIL cy_gr5: got %h want %h", dut.gr_q[5], m_gr[5]); end
        n_cmp++;
        if (pc !== 9'h35) begin n_bad++; $display("FAIL cy_pc: got %h want 35", pc); end
    endtask

    task automatic test_enable_freeze();
        int cyc;
        bit ok;
        logic [7:0] d;
        load_sum_prog();
        model_run();
        dut_run(400, 20, 20, 1'b0, cyc, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL frz_halt: halted=%0b want 1", halted); end
        n_cmp++;
        if (cyc != base_cyc + 20) begin n_bad++; $display("FAIL frz_delay: got %0d want %0d", cyc, base_cyc + 20); end
        n_cmp++;
        if (cyc != m_cyc + 20) begin n_bad++; $display("FAIL frz_cycles: got %0d want %0d", cyc, m_cyc + 20); end
        rd_byte(4, d);
        n_cmp++;
        if (d !== 8'h0A) begin n_bad++; $display("FAIL frz_sum: got %h want 0a", d); end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        bit ok;
        logic [7:0] d;
        load_sum_prog();
        dut_run(25, -1, 0, 1'b0, cyc, ok);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) m_gr[i] = 16'h0;
        m_zf = 1'b0; m_nf = 1'b0; m_cf = 1'b0;
        n_cmp++;
        if (running !== 1'b0) begin n_bad++; $display("FAIL mr_running: got %0b want 0", running); end
        n_cmp++;
        if (pc !== 9'd0) begin n_bad++; $display("FAIL mr_pc: got %0d want 0", pc); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (dut.gr_q[i] !== 16'h0) begin n_bad++; $display("FAIL mr_gr%0d: got %h want 0000", i, dut.gr_q[i]); end
        end
        for (int a = 32; a < 46; a++) begin
            rd_byte(a, d);
            n_cmp++;
            if (d !== m_mem[a]) begin n_bad++; $display("FAIL mr_ram%0d: got %h want %h", a, d, m_mem[a]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_run();
        dut_run(320, -1, 0, 1'b0, cyc, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL mr_halt: halted=%0b want 1", halted); end
        rd_byte(4, d);
        n_cmp++;
        if (d !== 8'h0A) begin n_bad++; $display("FAIL mr_sum: got %h want 0a", d); end
    endtask

    task automatic test_random();
        int cyc, kind, r1, r2, r3;
        bit ok;
        logic [7:0]  d;
        logic [15:0] ins;
        for (int it = 0; it < 4; it++) begin
            for (int b = 896; b < 928; b++) ld_byte(b, 8'($urandom));
            ld_word(0, enc_ri(SET, 7, 8'hF0));
            ld_word(1, enc_rrr(ADD, 7, 7, 7));
            ld_word(2, enc_rrr(ADD, 7, 7, 7));
            for (int k = 3; k < 27; k++) begin
                kind = $urandom_range(0, 10);
                r1 = $urandom_range(0, 6);
                r2 = $urandom_range(0, 7);
                r3 = $urandom_range(0, 7);
                case (kind)
                    0: ins = enc_ri(SET, r1, $urandom_range(0, 255));
                    1: ins = enc_rrr(ADD, r1, r2, r3);
                    2: ins = enc_rrr(SUB, r1, r2, r3);
                    3: ins = enc_ri(ADDI, r1, $urandom_range(0, 255));
                    4: ins = enc_ri(SUBI, r1, $urandom_range(0, 255));
                    5: ins = enc_mem(LOAD, r1, 7, $urandom_range(0, 15));
                    6: ins = enc_mem(STORE, r2, 7, $urandom_range(0, 15));
                    7: ins = enc_ri(BZ, 0, k + 2);
                    8: ins = enc_ri(BNZ, 0, k + 2);
                    9: ins = enc_ri(NOP, r1, $urandom_range(0, 255));
                    default: ins = enc_ri(5'($urandom_range(16, 23)), r1, $urandom_range(0, 255));
                endcase
                ld_word(k, ins);
            end
            ld_word(27, enc_ri(HALT, 0, 0));
            ld_word(28, enc_ri(HALT, 0, 0));
            model_run();
            dut_run(600, -1, 0, 1'b0, cyc, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL rnd%0d_halt: halted=%0b want 1", it, halted); end
            n_cmp++;
            if (cyc != m_cyc) begin n_bad++; $display("FAIL rnd%0d_cycles: got %0d want %0d", it, cyc, m_cyc); end
            n_cmp++;
            if (pc !== 9'(m_pc)) begin n_bad++; $display("FAIL rnd%0d_pc: got %0d want %0d", it, pc, m_pc); end
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (dut.gr_q[i] !== m_gr[i]) begin
                    n_bad++; $display("FAIL rnd%0d_gr%0d: got %h want %h", it, i, dut.gr_q[i], m_gr[i]);
                end
            end
            n_cmp++;
            if ({dut.zf_q, dut.nf_q, dut.cf_q} !== {m_zf, m_nf, m_cf}) begin
                n_bad++; $display("FAIL rnd%0d_flags: got %b want %b", it, {dut.zf_q, dut.nf_q, dut.cf_q}, {m_zf, m_nf, m_cf});
            end
            for (int b = 896; b < 928; b++) begin
                rd_byte(b, d);
                n_cmp++;
                if (d !== m_mem[b]) begin n_bad++; $display("FAIL rnd%0d_ram%0d: got %h want %h", it, b, d, m_mem[b]); end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) m_mem[a] = 8'h00;
        test_reset();
        test_loadport();
        test_loop_sum();
        test_load_flags();
        test_carry();
        test_enable_freeze();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
